// File: rtl/mem_refill_arbiter.sv
// Two-requester refill arbiter: grants one cache at a time onto a shared memory port,
// with round-robin priority and at most one transaction outstanding.
module mem_refill_arbiter #(
    parameter int unsigned RW = 175,
    parameter int unsigned SW = 145
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0_val,
    output logic          req0_rdy,
    input  logic [RW-1:0] req0_msg,

    input  logic          req1_val,
    output logic          req1_rdy,
    input  logic [RW-1:0] req1_msg,

    output logic          resp0_val,
    input  logic          resp0_rdy,
    output logic [SW-1:0] resp0_msg,

    output logic          resp1_val,
    input  logic          resp1_rdy,
    output logic [SW-1:0] resp1_msg,

    output logic          memreq_val,
    input  logic          memreq_rdy,
    output logic [RW-1:0] memreq_msg,

    input  logic          memresp_val,
    output logic          memresp_rdy,
    input  logic [SW-1:0] memresp_msg,

    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDeliver
    } state_e;

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic [RW-1:0] req_q, req_d;
    logic [SW-1:0] resp_q, resp_d;

    logic          any_req;
    logic          winner;
    logic          grant_ok;
    logic          owner_rdy;

    always_comb begin
        any_req   = req0_val | req1_val;
        winner    = (req0_val & req1_val) ? prio_q : req1_val;
        // Grant is gated by reset so no rdy leaks out while the block is held in reset.
        grant_ok  = reset & (state_q == StIdle) & any_req;
        owner_rdy = owner_q ? resp1_rdy : resp0_rdy;
    end

    assign req0_rdy    = grant_ok & ~winner;
    assign req1_rdy    = grant_ok & winner;

    assign memreq_val  = (state_q == StIssue);
    assign memreq_msg  = req_q;
    assign memresp_rdy = (state_q == StWait);

    assign resp0_val   = (state_q == StDeliver) & ~owner_q;
    assign resp1_val   = (state_q == StDeliver) & owner_q;
    assign resp0_msg   = resp_q;
    assign resp1_msg   = resp_q;

    assign owner       = owner_q;
    assign busy        = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        req_d   = req_q;
        resp_d  = resp_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ok) begin
                    req_d   = winner ? req1_msg : req0_msg;
                    owner_d = winner;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (memreq_rdy) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (memresp_val) begin
                    resp_d  = memresp_msg;
                    state_d = StDeliver;
                end
            end
            StDeliver: begin
                if (owner_rdy) begin
                    prio_d  = ~owner_q;
                    owner_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            req_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
        end
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: table of transactions plus hand-written reset sequences,
// with a response scoreboard filled at grant time and drained at delivery.
module tb_mem_refill_arbiter;

    localparam int RW = 175;
    localparam int SW = 145;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_val = 1'b0, req1_val = 1'b0;
    logic          req0_rdy, req1_rdy;
    logic [RW-1:0] req0_msg = '0, req1_msg = '0;
    logic          resp0_val, resp1_val;
    logic          resp0_rdy = 1'b0, resp1_rdy = 1'b0;
    logic [SW-1:0] resp0_msg, resp1_msg;
    logic          memreq_val;
    logic          memreq_rdy = 1'b0;
    logic [RW-1:0] memreq_msg;
    logic          memresp_val = 1'b0;
    logic          memresp_rdy;
    logic [SW-1:0] memresp_msg = '0;
    logic          owner, busy;

    mem_refill_arbiter #(.RW(RW), .SW(SW)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chkr(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chks(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [RW-1:0] mk_req(input logic [31:0] addr);
        return {3'd0, 8'd0, addr, 4'd0, 96'd0, addr};
    endfunction

    function automatic logic [SW-1:0] mk_resp(input logic [127:0] data);
        return {3'd0, 8'd0, 2'd0, 4'd0, data};
    endfunction

    typedef struct {
        logic owner;
        logic [SW-1:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, a1;
        logic [127:0] d;
        logic        eo;
        int          ms, rs;
        logic        hold, pulse;
    } vec_t;
    vec_t vecs[13];

    // Called at a negedge in IDLE; drives requests, checks the grant, ends just after posedge.
    task automatic accept(input logic v0, input logic v1, input logic [RW-1:0] m0,
                          input logic [RW-1:0] m1, input logic eo, input logic [SW-1:0] data);
        sb_t e;
        req0_val = v0; req1_val = v1; req0_msg = m0; req1_msg = m1;
        #1;
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_owner", owner, 1'b0);
        chk1("grant0", req0_rdy, v0 & ~eo);
        chk1("grant1", req1_rdy, v1 & eo);
        chk1("idle_memreq_val", memreq_val, 1'b0);
        e.owner = eo; e.data = data;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Runs ISSUE/WAIT/DELIVER with optional stalls; returns at the negedge of the next IDLE cycle.
    task automatic finish_txn(input logic eo, input logic [RW-1:0] exp_msg,
                              input logic [SW-1:0] data, input int ms, input int rs,
                              input logic hold, input logic pulse);
        sb_t e;
        @(negedge clk);
        if (!hold) begin req0_val = 1'b0; req1_val = 1'b0; end
        for (int i = 0; i <= ms; i++) begin
            memreq_rdy  = (i == ms);
            memresp_val = pulse && (i < ms);
            memresp_msg = ~data;
            #1;
            chk1("issue_val", memreq_val, 1'b1);
            chkr("issue_msg", memreq_msg, exp_msg);
            chk1("issue_owner", owner, eo);
            chk1("issue_busy", busy, 1'b1);
            chk1("issue_req_rdy", req0_rdy | req1_rdy, 1'b0);
            chk1("issue_memresp_rdy", memresp_rdy, 1'b0);
            chk1("issue_resp_val", resp0_val | resp1_val, 1'b0);
            @(posedge clk); @(negedge clk);
        end
        memreq_rdy  = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = data;
        #1;
        chk1("wait_memresp_rdy", memresp_rdy, 1'b1);
        chk1("wait_memreq_val", memreq_val, 1'b0);
        chk1("wait_req_rdy", req0_rdy | req1_rdy, 1'b0);
        @(posedge clk); @(negedge clk);
        memresp_val = 1'b0;
        memresp_msg = '0;
        for (int i = 0; i <= rs; i++) begin
            resp0_rdy = (i == rs);
            resp1_rdy = (i == rs);
            #1;
            chk1("deliver_resp0_val", resp0_val, ~eo);
            chk1("deliver_resp1_val", resp1_val, eo);
            chks("deliver_resp0_msg", resp0_msg, data);
            chks("deliver_resp1_msg", resp1_msg, data);
            chk1("deliver_busy", busy, 1'b1);
            chk1("deliver_req_rdy", req0_rdy | req1_rdy, 1'b0);
            chk1("deliver_memresp_rdy", memresp_rdy, 1'b0);
            if (i == rs) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_underflow: got response want none queued");
                end else begin
                    n_pass++;
                    e = sb.pop_front();
                    chk1("sb_owner", resp1_val, e.owner);
                    chks("sb_data", resp1_val ? resp1_msg : resp0_msg, e.data);
                end
            end
            @(posedge clk); @(negedge clk);
        end
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        #1;
        chk1("end_busy", busy, 1'b0);
        chk1("end_owner", owner, 1'b0);
    endtask

    // Starts a transaction, reaches WAIT, then resets asynchronously mid-cycle.
    task automatic abort_in_wait(input logic v0, input logic v1, input logic eo);
        accept(v0, v1, mk_req(32'h3000), mk_req(32'h3100), eo, mk_resp(128'h0));
        @(negedge clk);
        req0_val = 1'b0; req1_val = 1'b0;
        memreq_rdy = 1'b1;
        @(posedge clk); @(negedge clk);
        memreq_rdy = 1'b0;
        #1;
        chk1("abort_pre_memresp_rdy", memresp_rdy, 1'b1);
        #2;
        reset = 1'b0;
        req0_val = 1'b1; req1_val = 1'b1;
        #1;
        chk1("rst_memresp_rdy", memresp_rdy, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_vals", memreq_val | resp0_val | resp1_val, 1'b0);
        chk1("rst_req_rdy", req0_rdy | req1_rdy, 1'b0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v0    v1    a0        a1        data          eo    ms rs hold  pulse
        vecs[0]  = '{1'b1, 1'b1, 32'h0100, 32'h0200, 128'h11,      1'b0, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0104, 32'h0204, 128'h22,      1'b1, 0, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h1000, 32'h0,    128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF,
                     1'b0, 0, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0,    32'h2000, 128'hCAFE,    1'b1, 5, 3, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 32'h0400, 32'h0500, 128'h40,      1'b0, 0, 0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0400, 32'h0500, 128'h41,      1'b1, 0, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h0400, 32'h0500, 128'h42,      1'b0, 0, 0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0400, 32'h0500, 128'h43,      1'b1, 0, 0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0400, 32'h0500, 128'h44,      1'b0, 0, 0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0400, 32'h0500, 128'h45,      1'b1, 0, 0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h0,    32'h0600, 128'h60,      1'b1, 1, 1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0700, 32'h0,    128'h70,      1'b0, 0, 2, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0800, 32'h0,    128'h80,      1'b0, 2, 0, 1'b0, 1'b0};

        // Held in reset with requests pending: nothing may be granted or valid.
        req0_val = 1'b1; req1_val = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk1("reset_req_rdy", req0_rdy | req1_rdy, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_vals", memreq_val | resp0_val | resp1_val | memresp_rdy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        req0_val = 1'b0; req1_val = 1'b0;

        // Idle with no requests, stray memory response must be ignored.
        memresp_val = 1'b1;
        memresp_msg = mk_resp(128'hBAD);
        #1;
        chk1("idle_no_rdy", req0_rdy | req1_rdy, 1'b0);
        chk1("idle_memresp_rdy", memresp_rdy, 1'b0);
        @(posedge clk); @(negedge clk);
        memresp_val = 1'b0;
        #1;
        chk1("idle_stay", busy, 1'b0);
        chk1("idle_no_resp", resp0_val | resp1_val, 1'b0);

        for (int k = 0; k < 13; k++) begin
            logic [RW-1:0] m0, m1;
            m0 = mk_req(vecs[k].a0);
            m1 = mk_req(vecs[k].a1);
            accept(vecs[k].v0, vecs[k].v1, m0, m1, vecs[k].eo, mk_resp(vecs[k].d));
            finish_txn(vecs[k].eo, vecs[k].eo ? m1 : m0, mk_resp(vecs[k].d),
                       vecs[k].ms, vecs[k].rs, vecs[k].hold, vecs[k].pulse);
        end

        // prio is 1 here; after the abort it must restart at 0.
        abort_in_wait(1'b0, 1'b1, 1'b1);
        accept(1'b1, 1'b1, mk_req(32'h4000), mk_req(32'h4100), 1'b0, mk_resp(128'h4444));
        finish_txn(1'b0, mk_req(32'h4000), mk_resp(128'h4444), 0, 0, 1'b0, 1'b0);

        // req1 must be accepted in the very first cycle after release.
        abort_in_wait(1'b1, 1'b0, 1'b0);
        accept(1'b0, 1'b1, mk_req(32'h5000), mk_req(32'h5100), 1'b1, mk_resp(128'h5555));
        finish_txn(1'b1, mk_req(32'h5100), mk_resp(128'h5555), 0, 0, 1'b0, 1'b0);

        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_leftover: got %0d entries want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
